cpu6_shftctl: RTL and testbench

- Multi-cycle shift sequencer for the cpu6 execute stage. It handles SLL/SLLI, SRL/SRLI and SRA/SRAI.
- It is started by the decoder's shft_en/shft_lr outputs. It shifts STEP bits per cycle and stalls the pipeline until the result is ready, replacing a full barrel shifter.
- The ALU result mux selects shft_result when shft_done=1.

---
 rtl/cpu6_shftctl.sv | 117 +++++++++++
 tb/tb_cpu6_shftctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_shftctl.sv
// cpu6_shftctl: multi-cycle shift sequencer for the cpu6 execute stage.
// Shifts STEP bits per cycle and stalls the pipeline until the result of
// SLL/SRL/SRA (and immediate forms) is ready, instead of a barrel shifter.
module cpu6_shftctl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               shft_en,
  input  logic               shft_lr,
  input  logic               shft_arith,
  input  logic [XLEN-1:0]    shft_src,
  input  logic [SHAMT_W-1:0] shft_amt,
  input  logic               ex_flush,
  output logic               shft_stall,
  output logic               shft_done,
  output logic [XLEN-1:0]    shft_result,
  output logic               shft_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state_q, state_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               ar_q, ar_d;

  logic               accept;
  logic [SHAMT_W-1:0] step_n;
  logic [SHAMT_W-1:0] cnt_rem;

  // Per-cycle shift amount (never more than what is left) and accept decode.
  always_comb begin
    step_n  = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;
    cnt_rem = cnt_q - step_n;
    accept  = (state_q == IDLE) && shft_en && !ex_flush;
  end

  // Next-state and datapath update; a flush wins over everything.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ar_d    = ar_q;

    if (ex_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_d  = shft_src;
            cnt_d   = shft_amt;
            dir_d   = shft_lr;
            ar_d    = shft_arith & shft_lr;
            state_d = (shft_amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          if (!dir_q) begin
            data_d = data_q << step_n;
          end else if (ar_q) begin
            data_d = XLEN'($signed(data_q) >>> step_n);
          end else begin
            data_d = data_q >> step_n;
          end
          cnt_d = cnt_rem;
          if (cnt_rem == '0) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!resetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ar_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ar_q    <= ar_d;
    end
  end

  // Pipeline-facing outputs; stall drops in DONE so EX advances with the result.
  always_comb begin
    shft_stall  = accept || ((state_q == SHIFT) && !ex_flush);
    shft_done   = (state_q == DONE) && !ex_flush;
    shft_busy   = (state_q != IDLE);
    shft_result = data_q;
  end

endmodule

// File: tb/tb_cpu6_shftctl.sv
// Directed bench for cpu6_shftctl: one STEP=1 and one STEP=4 instance.
module tb_cpu6_shftctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en1, en4;
  logic        lr_i, ar_i, ex_flush;
  logic [31:0] src_i;
  logic [4:0]  amt_i;

  logic        stall1, done1, busy1;
  logic        stall4, done4, busy4;
  logic [31:0] res1, res4;

  bit          use4;
  logic        stall_m, done_m, busy_m;
  logic [31:0] res_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu6_shftctl #(.XLEN(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .shft_en(en1), .shft_lr(lr_i),
    .shft_arith(ar_i), .shft_src(src_i), .shft_amt(amt_i),
    .ex_flush(ex_flush), .shft_stall(stall1), .shft_done(done1),
    .shft_result(res1), .shft_busy(busy1)
  );

  cpu6_shftctl #(.XLEN(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .shft_en(en4), .shft_lr(lr_i),
    .shft_arith(ar_i), .shft_src(src_i), .shft_amt(amt_i),
    .ex_flush(ex_flush), .shft_stall(stall4), .shft_done(done4),
    .shft_result(res4), .shft_busy(busy4)
  );

  // Route the selected instance's outputs to the checking code.
  always_comb begin
    stall_m = use4 ? stall4 : stall1;
    done_m  = use4 ? done4  : done1;
    busy_m  = use4 ? busy4  : busy1;
    res_m   = use4 ? res4   : res1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one shift in the IDLE cycle, follow it to DONE and check result,
  // stall-cycle count and that holding shft_en through DONE does not restart.
  task automatic run_op(input string tag, input bit u4, input logic [31:0] src,
                        input logic [4:0] amt, input bit lr, input bit ar,
                        input logic [31:0] exp, input int exp_stall, input bit keep_en);
    int  nst;
    bit  found;
    use4  = u4;
    src_i = src;
    amt_i = amt;
    lr_i  = lr;
    ar_i  = ar;
    en1   = !u4;
    en4   = u4;
    #1;
    chk({tag, "_idle_at_accept"}, 32'(busy_m), 32'd0);
    nst   = 0;
    found = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (done_m) begin
        found = 1'b1;
        break;
      end
      if (stall_m) nst++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_result"}, res_m, exp);
      chk({tag, "_stall_in_done"}, 32'(stall_m), 32'd0);
      chk({tag, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
    end
    @(posedge clk);
    #1;
    if (!keep_en) begin
      en1 = 1'b0;
      en4 = 1'b0;
      #1;
      chk({tag, "_no_restart_busy"}, 32'(busy_m), 32'd0);
      chk({tag, "_no_restart_done"}, 32'(done_m), 32'd0);
      chk({tag, "_result_hold"}, res_m, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    int dones;
    resetn   = 1'b0;
    en1      = 1'b0;
    en4      = 1'b0;
    lr_i     = 1'b0;
    ar_i     = 1'b0;
    ex_flush = 1'b0;
    src_i    = 32'h0;
    amt_i    = 5'd0;
    use4     = 1'b0;
    cycles(2);
    resetn = 1'b1;
    #1;

    // Reset state of both instances.
    chk("rst_busy1",   32'(busy1),  32'd0);
    chk("rst_stall1",  32'(stall1), 32'd0);
    chk("rst_done1",   32'(done1),  32'd0);
    chk("rst_result1", res1,        32'h0);
    chk("rst_busy4",   32'(busy4),  32'd0);
    chk("rst_result4", res4,        32'h0);

    // STEP=1 directed shifts.
    run_op("sll4",    1'b0, 32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0000_0010, 5,  1'b0);
    run_op("sra31",   1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 32, 1'b0);
    run_op("srl31",   1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 32, 1'b0);
    run_op("amt0",    1'b0, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1,  1'b0);
    run_op("sll_ari", 1'b0, 32'h8000_0001, 5'd3,  1'b0, 1'b1, 32'h0000_0008, 4,  1'b0);

    // STEP=4: shift 4 then 3.
    run_op("s4_srl7", 1'b1, 32'hF000_0000, 5'd7,  1'b1, 1'b0, 32'h01E0_0000, 3,  1'b0);
    run_op("s4_sra5", 1'b1, 32'h8000_0000, 5'd5,  1'b1, 1'b1, 32'hFC00_0000, 3,  1'b0);
    run_op("s4_sll9", 1'b1, 32'h0000_0003, 5'd9,  1'b0, 1'b0, 32'h0000_0600, 4,  1'b0);

    // Flush in the third SHIFT cycle of an amt=10 shift.
    use4  = 1'b0;
    src_i = 32'h0000_0001;
    amt_i = 5'd10;
    lr_i  = 1'b0;
    ar_i  = 1'b0;
    en1   = 1'b1;
    cycles(3);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall1), 32'd0);
    chk("flush_done",  32'(done1),  32'd0);
    @(posedge clk);
    #1;
    ex_flush = 1'b0;
    en1      = 1'b0;
    #1;
    chk("flush_idle",       32'(busy1),  32'd0);
    chk("flush_idle_stall", 32'(stall1), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (done1) dones++;
    end
    chk("flush_no_done", 32'(dones), 32'd0);
    run_op("post_flush", 1'b0, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0002, 2, 1'b0);

    // Reset pulse in the middle of a shift.
    src_i = 32'h1234_5678;
    amt_i = 5'd10;
    lr_i  = 1'b1;
    ar_i  = 1'b0;
    en1   = 1'b1;
    cycles(3);
    resetn = 1'b0;
    en1    = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy1),  32'd0);
    chk("mid_rst_stall",  32'(stall1), 32'd0);
    chk("mid_rst_done",   32'(done1),  32'd0);
    chk("mid_rst_result", res1,        32'h0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (done1) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);

    // Back-to-back: second instruction accepted in the IDLE cycle after DONE.
    run_op("b2b_sll2", 1'b0, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 3, 1'b1);
    run_op("b2b_srl1", 1'b0, 32'h0000_0080, 5'd1, 1'b1, 1'b0, 32'h0000_0040, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
